// File: rtl/nlseq_pkg.sv
// nlseq_pkg: shared state encoding and width helpers for the layer sequencer
package nlseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction

    function automatic int addr_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/nlseq_argmax.sv
// nlseq_argmax: running signed maximum with index; clr re-arms, first upd after clr loads unconditionally
module nlseq_argmax
    import nlseq_pkg::*;
#(
    parameter int AW  = 2,
    parameter int D_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  upd,
    input  logic [AW-1:0]         upd_idx,
    input  logic signed [D_W-1:0] upd_val,
    output logic [AW-1:0]         max_idx
);

    logic signed [D_W-1:0] max_val;
    logic                  have;

    // strictly greater replaces, so ties keep the lowest index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_val <= '0;
            max_idx <= '0;
            have    <= 1'b0;
        end else if (clr) begin
            have <= 1'b0;
        end else if (upd && (!have || upd_val > max_val)) begin
            max_val <= upd_val;
            max_idx <= upd_idx;
            have    <= 1'b1;
        end
    end

endmodule

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: runs one dense layer through a serial MAC neuron; NLSEQ_ARGMAX_EN adds m_argmax
module neuron_layer_seq
    import nlseq_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 8,
    parameter int X_W         = 8,
    parameter int W_W         = 8,
    parameter int B_W         = 16,
    parameter int OUT_W       = 16,
    parameter int AW          = addr_w(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_INPUTS*X_W-1:0]    s_x_flat,
    output logic                         wmem_en,
    output logic [AW-1:0]                wmem_addr,
    input  logic [NUM_INPUTS*W_W-1:0]    wmem_w_flat,
    input  logic [B_W-1:0]               wmem_bias,
    output logic                         n_in_valid,
    input  logic                         n_in_ready,
    output logic [B_W-1:0]               n_bias,
    output logic [NUM_INPUTS*X_W-1:0]    n_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]    n_w_flat,
    input  logic                         n_out_valid,
    input  logic [OUT_W-1:0]             n_out_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_NEURONS*OUT_W-1:0] m_y_flat,
    output logic                         busy
`ifdef NLSEQ_ARGMAX_EN
    ,
    output logic [AW-1:0]                m_argmax
`endif
);

    state_t        state;
    logic [AW-1:0] idx;
    logic          capture;

    assign s_ready    = state == IDLE;
    assign busy       = state != IDLE;
    assign wmem_en    = state == FETCH;
    assign n_in_valid = state == ISSUE;
    assign m_valid    = state == DONE;
    assign wmem_addr  = idx;
    assign capture    = state == WAIT && n_out_valid;

    // layer sequencer: fetch weights, issue the job, collect each result, present the vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            n_x_flat <= '0;
            n_w_flat <= '0;
            n_bias   <= '0;
            m_y_flat <= '0;
        end else begin
            case (state)
                IDLE: if (s_valid) begin
                    n_x_flat <= s_x_flat;
                    idx      <= '0;
                    state    <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    n_w_flat <= wmem_w_flat;
                    n_bias   <= wmem_bias;
                    state    <= ISSUE;
                end
                ISSUE: if (n_in_ready) state <= WAIT;
                WAIT: if (capture) begin
                    m_y_flat[int'(idx)*OUT_W +: OUT_W] <= n_out_data;
                    if (idx == AW'(NUM_NEURONS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: if (m_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NLSEQ_ARGMAX_EN
    nlseq_argmax #(
        .AW (AW),
        .D_W(OUT_W)
    ) u_argmax (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (s_ready && s_valid),
        .upd    (capture),
        .upd_idx(idx),
        .upd_val(n_out_data),
        .max_idx(m_argmax)
    );
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq: directed bench with a weight memory, a ReLU neuron peer and a layer-level reference model
module tb_neuron_layer_seq;

    localparam int NN = 4;
    localparam int NI = 8;
    localparam int OW = 16;
    localparam int AW = 2;
    localparam int BASE_LAT = NN * (NI + 4);

    logic              clk = 0;
    logic              rst_n = 0;
    logic              s_valid = 0;
    logic              s_ready;
    logic [NI*8-1:0]   s_x_flat = '0;
    logic              wmem_en;
    logic [AW-1:0]     wmem_addr;
    logic [NI*8-1:0]   wmem_w_flat = '0;
    logic [15:0]       wmem_bias = '0;
    logic              n_in_valid;
    logic              n_in_ready = 1;
    logic [15:0]       n_bias;
    logic [NI*8-1:0]   n_x_flat;
    logic [NI*8-1:0]   n_w_flat;
    logic              n_out_valid;
    logic [OW-1:0]     n_out_data;
    logic              m_valid;
    logic              m_ready = 0;
    logic [NN*OW-1:0]  m_y_flat;
    logic              busy;
`ifdef NLSEQ_ARGMAX_EN
    logic [AW-1:0]     m_argmax;
`endif

    logic signed [7:0]  xv [NI];
    logic signed [7:0]  wv [NN][NI];
    logic signed [15:0] bv [NN];

    logic [NN*OW-1:0] exp_y = '0;
    int               exp_am = 0;
    int               tests = 0;
    int               fails = 0;
    int               stall_k = -1;
    logic             spur = 0;
    logic             nv = 0;
    logic [OW-1:0]    n_res = '0;
    int               pend = 0;
    logic [63:0]      sx, sw;
    logic [15:0]      sb;

    assign n_out_valid = nv | spur;
    assign n_out_data  = n_res;

    always #5 clk = ~clk;

    neuron_layer_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x_flat   (s_x_flat),
        .wmem_en    (wmem_en),
        .wmem_addr  (wmem_addr),
        .wmem_w_flat(wmem_w_flat),
        .wmem_bias  (wmem_bias),
        .n_in_valid (n_in_valid),
        .n_in_ready (n_in_ready),
        .n_bias     (n_bias),
        .n_x_flat   (n_x_flat),
        .n_w_flat   (n_w_flat),
        .n_out_valid(n_out_valid),
        .n_out_data (n_out_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_y_flat   (m_y_flat),
`ifdef NLSEQ_ARGMAX_EN
        .m_argmax   (m_argmax),
`endif
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [NI*8-1:0] pack_x();
        logic [NI*8-1:0] f;
        for (int i = 0; i < NI; i++) f[i*8 +: 8] = xv[i];
        return f;
    endfunction

    function automatic logic [NI*8-1:0] pack_w(input int k);
        logic [NI*8-1:0] f;
        for (int i = 0; i < NI; i++) f[i*8 +: 8] = wv[k][i];
        return f;
    endfunction

    // reference: each slot is relu(bias + dot(x, w)), argmax is the first largest slot
    function automatic logic [NN*OW-1:0] model_y();
        logic [NN*OW-1:0] y;
        for (int k = 0; k < NN; k++) begin
            int acc;
            acc = bv[k];
            for (int i = 0; i < NI; i++) acc += xv[i] * wv[k][i];
            y[k*OW +: OW] = (acc < 0) ? 16'd0 : 16'(acc);
        end
        return y;
    endfunction

    function automatic int model_am(input logic [NN*OW-1:0] y);
        int m = 0;
        for (int k = 1; k < NN; k++)
            if ($signed(y[k*OW +: OW]) > $signed(y[m*OW +: OW])) m = k;
        return m;
    endfunction

    // synchronous weight memory: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (wmem_en) begin
            wmem_w_flat <= pack_w(int'(wmem_addr));
            wmem_bias   <= bv[wmem_addr];
        end
    end

    // companion ReLU neuron: always ready, result pulses NI+1 edges after accept
    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 0;
            nv   <= 0;
        end else begin
            nv <= 0;
            if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) nv <= 1;
            end
            if (n_in_valid && n_in_ready) begin
                int acc;
                acc = $signed(n_bias);
                for (int i = 0; i < NI; i++) acc += $signed(n_x_flat[i*8 +: 8]) * $signed(n_w_flat[i*8 +: 8]);
                n_res <= (acc < 0) ? 16'd0 : 16'(acc);
                pend  <= NI;
            end
        end
    end

    // compare process: handshake decode every cycle, output vector whenever it is presented
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("ready_vs_busy", s_ready, !busy);
            if (m_valid) begin
                chk("y_vector", m_y_flat, exp_y);
`ifdef NLSEQ_ARGMAX_EN
                chk("argmax", m_argmax, exp_am);
`endif
            end
        end
    end

    // optional input stall: hold n_in_ready low for 5 ISSUE cycles of neuron stall_k
    initial forever begin
        @(negedge clk);
        if (stall_k >= 0 && wmem_en && int'(wmem_addr) == stall_k) begin
            n_in_ready = 0;
            @(negedge clk);
            @(negedge clk);
            sx = n_x_flat;
            sw = n_w_flat;
            sb = n_bias;
            chk("stall_w_loaded", sw, pack_w(stall_k));
            chk("stall_b_loaded", sb, bv[stall_k]);
            stall_k = -1;
            repeat (5) begin
                @(negedge clk);
                chk("stall_valid", n_in_valid, 1);
                chk("stall_x", n_x_flat, sx);
                chk("stall_w", n_w_flat, sw);
                chk("stall_b", n_bias, sb);
            end
            n_in_ready = 1;
        end
    end

    task automatic chk_reset();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wmem_en", wmem_en, 0);
        chk("rst_wmem_addr", wmem_addr, 0);
        chk("rst_n_in_valid", n_in_valid, 0);
        chk("rst_n_bias", n_bias, 0);
        chk("rst_n_x", n_x_flat, 0);
        chk("rst_n_w", n_w_flat, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_y", m_y_flat, 0);
`ifdef NLSEQ_ARGMAX_EN
        chk("rst_argmax", m_argmax, 0);
`endif
    endtask

    task automatic run_layer(input int extra, input int hold, input bit spur_fetch);
        int lat;
        logic [NI*8-1:0] xf;
        exp_y  = model_y();
        exp_am = model_am(exp_y);
        xf = pack_x();
        @(negedge clk);
        chk("start_ready", s_ready, 1);
        s_x_flat = xf;
        s_valid  = 1;
        @(negedge clk);
        s_valid = 0;
        chk("accepted_busy", busy, 1);
        if (spur_fetch) begin
            chk("fetch_strobe", wmem_en, 1);
            spur = 1;
        end
        lat = 0;
        while (!m_valid && lat < 400) begin
            @(negedge clk);
            spur = 0;
            lat++;
        end
        chk("latency", lat, BASE_LAT + extra);
        for (int j = 0; j < hold; j++) begin
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
            s_valid = (j == 3);
            s_x_flat = ~xf;
            @(negedge clk);
        end
        s_valid = 0;
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        chk("post_m_valid", m_valid, 0);
        chk("post_s_ready", s_ready, 1);
        chk("post_x_kept", n_x_flat, xf);
    endtask

    task automatic set_basic(input int tie);
        for (int i = 0; i < NI; i++) xv[i] = 1;
        for (int k = 0; k < NN; k++) begin
            for (int i = 0; i < NI; i++) wv[k][i] = 8'(k);
            bv[k] = 0;
        end
        if (tie != 0) begin
            bv[0] = 5;
            bv[1] = 1;
            bv[2] = -7;
            bv[3] = -22;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1;

        set_basic(0);
        run_layer(0, 0, 0);
        chk("basic_y_literal", m_y_flat, 64'h0018_0010_0008_0000);
        chk("basic_model_literal", exp_y, 64'h0018_0010_0008_0000);
`ifdef NLSEQ_ARGMAX_EN
        chk("basic_argmax_literal", m_argmax, 3);
`endif

        @(negedge clk);
        spur = 1;
        @(negedge clk);
        spur = 0;
        chk("spur_idle_ready", s_ready, 1);
        chk("spur_idle_y", m_y_flat, 64'h0018_0010_0008_0000);
        @(negedge clk);
        chk("spur_idle_busy", busy, 0);

        stall_k = 2;
        run_layer(5, 0, 0);
        chk("stall_y_literal", m_y_flat, 64'h0018_0010_0008_0000);

        for (int i = 0; i < NI; i++) xv[i] = 8'(i - 3);
        for (int j = 0; j < NN; j++) begin
            for (int i = 0; i < NI; i++) wv[j][i] = 8'((j + 1) * ((i % 3) - 1) * 5);
            bv[j] = 16'(j * 100 - 150);
        end
        run_layer(0, 10, 0);

        set_basic(0);
        for (int i = 0; i < NI; i++) xv[i] = 2;
        run_layer(0, 0, 1);
        chk("spur_fetch_y_literal", m_y_flat, 64'h0030_0020_0010_0000);

        set_basic(0);
        @(negedge clk);
        s_x_flat = pack_x();
        s_valid = 1;
        @(negedge clk);
        s_valid = 0;
        k = 0;
        while (!(wmem_en && wmem_addr == 1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_neuron1", k < 100, 1);
        repeat (4) @(negedge clk);
        chk("mid_wait_busy", busy, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk_reset();
        run_layer(0, 0, 0);
        chk("after_reset_y", m_y_flat, 64'h0018_0010_0008_0000);

        set_basic(1);
        run_layer(0, 0, 0);
        chk("tie_y_literal", m_y_flat, 64'h0002_0009_0009_0005);
`ifdef NLSEQ_ARGMAX_EN
        chk("tie_argmax_literal", m_argmax, 1);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
